// File: rtl/tri_seq_ctrl.sv
// tri_seq_ctrl: point-in-triangle tester, one shared edge-sign unit.
// Optional macro TRI_EARLY_EXIT_EN: skip edge 2 once the outcome is known.
module tri_seq_ctrl #(
  parameter int W     = 12,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] x0,
  input  logic signed [W-1:0] y0,
  input  logic signed [W-1:0] x1,
  input  logic signed [W-1:0] y1,
  input  logic signed [W-1:0] x2,
  input  logic signed [W-1:0] y2,
  input  logic signed [W-1:0] x3,
  input  logic signed [W-1:0] y3,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_in,
  output logic                busy,
  input  logic                clr_cnt,
  output logic [CNT_W-1:0]    hit_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    EDGE0,
    EDGE1,
    EDGE2,
    DONE
  } state_t;

  localparam int DW = W + 1;
  localparam int PW = 2 * W + 2;

  state_t state, nstate;

  logic signed [W-1:0] px [4];
  logic signed [W-1:0] py [4];
  logic signed [W-1:0] bx, by, cx, cy;
  logic signed [DW-1:0] d1, d2, d3, d4;
  logic signed [PW-1:0] p1, p2;
  logic s;
  logic g0, g1;
  logic acc, hs;

  function automatic logic signed [DW-1:0] ext1(
    input logic signed [W-1:0] v
  );
    return {v[W-1], v};
  endfunction

  function automatic logic signed [PW-1:0] ext2(
    input logic signed [DW-1:0] v
  );
    return {{(PW-DW){v[DW-1]}}, v};
  endfunction

  assign acc = in_valid & in_ready;
  assign hs  = out_valid & out_ready;

  // Operand select for the shared sign unit.
  always_comb begin
    bx = px[1];
    by = py[1];
    cx = px[2];
    cy = py[2];
    unique case (1'b1)
      state == EDGE1: begin
        bx = px[2];
        by = py[2];
        cx = px[3];
        cy = py[3];
      end
      state == EDGE2: begin
        bx = px[3];
        by = py[3];
        cx = px[1];
        cy = py[1];
      end
      default: ;
    endcase
  end

  // Edge sign: widened differences and products so nothing wraps.
  always_comb begin
    d1 = ext1(px[0]) - ext1(cx);
    d2 = ext1(by) - ext1(cy);
    d3 = ext1(bx) - ext1(cx);
    d4 = ext1(py[0]) - ext1(cy);
    p1 = ext2(d1) * ext2(d2);
    p2 = ext2(d3) * ext2(d4);
    s  = (p1 < p2);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  // Next-state logic.
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:  if (acc) nstate = EDGE0;
      EDGE0: nstate = EDGE1;
`ifdef TRI_EARLY_EXIT_EN
      EDGE1: nstate = (s != g0) ? DONE : EDGE2;
`else
      EDGE1: nstate = EDGE2;
`endif
      EDGE2: nstate = DONE;
      DONE:  if (out_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state.
  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    out_valid = (state == DONE);
  end

  // Query capture, per-edge signs and the registered verdict.
  // The edge-2 sign feeds the verdict directly, so it needs no flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        px[i] <= '0;
        py[i] <= '0;
      end
      g0     <= 1'b0;
      g1     <= 1'b0;
      out_in <= 1'b0;
    end else begin
      if (acc) begin
        px[0] <= x0;
        py[0] <= y0;
        px[1] <= x1;
        py[1] <= y1;
        px[2] <= x2;
        py[2] <= y2;
        px[3] <= x3;
        py[3] <= y3;
      end
      if (state == EDGE0) g0 <= s;
      if (state == EDGE1) begin
        g1 <= s;
`ifdef TRI_EARLY_EXIT_EN
        if (s != g0) out_in <= 1'b0;
`endif
      end
      if (state == EDGE2) out_in <= (g0 == g1) && (g1 == s);
    end
  end

  // Saturating hit counter; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt <= '0;
    end else if (clr_cnt) begin
      hit_cnt <= '0;
    end else if (hs && out_in && !(&hit_cnt)) begin
      hit_cnt <= hit_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_tri_seq_ctrl.sv
// tb_tri_seq_ctrl: directed and random checks of tri_seq_ctrl
// against a transaction-level reference model.
module tb_tri_seq_ctrl;

  localparam int W  = 12;
  localparam int CW = 16;
  localparam int SW = 3;
`ifdef TRI_EARLY_EXIT_EN
  localparam int LOUT = 2;
`else
  localparam int LOUT = 3;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic clr_cnt = 1'b0;
  logic signed [W-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic signed [W-1:0] x2 = '0, y2 = '0, x3 = '0, y3 = '0;

  logic in_ready, out_valid, out_in, busy;
  logic [CW-1:0] hit_cnt;
  logic in_ready_s, out_valid_s, out_in_s, busy_s;
  logic [SW-1:0] hit_cnt_s;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  tri_seq_ctrl #(.W(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .x2(x2), .y2(y2), .x3(x3), .y3(y3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_in(out_in), .busy(busy),
    .clr_cnt(clr_cnt), .hit_cnt(hit_cnt)
  );

  tri_seq_ctrl #(.W(W), .CNT_W(SW)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_s),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .x2(x2), .y2(y2), .x3(x3), .y3(y3),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .out_in(out_in_s), .busy(busy_s),
    .clr_cnt(clr_cnt), .hit_cnt(hit_cnt_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Which side of edge b->c the point a lies on.
  function automatic bit side(input longint ax, ay, bx, by, cx, cy);
    return (ax - cx) * (by - cy) < (bx - cx) * (ay - cy);
  endfunction

  // Reference model: one pending query, a countdown to its result,
  // and ideal saturating counters for both counter widths.
  bit     m_pend = 0;
  int     m_left = 0;
  bit     m_in = 0;
  longint m_cnt = 0;
  longint m_cnt_s = 0;
  bit     m_g0, m_g1, m_g2, m_hs;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_hit_cnt", hit_cnt, 0);
      m_pend = 0;
      m_cnt = 0;
      m_cnt_s = 0;
    end else begin
      chk("in_ready", in_ready, !m_pend);
      chk("busy", busy, m_pend);
      chk("out_valid", out_valid, m_pend && m_left == 0);
      chk("out_valid_s", out_valid_s, m_pend && m_left == 0);
      if (m_pend && m_left == 0) begin
        chk("out_in", out_in, m_in);
        chk("out_in_s", out_in_s, m_in);
      end
      chk("hit_cnt", hit_cnt, m_cnt);
      chk("hit_cnt_s", hit_cnt_s, m_cnt_s);
      m_hs = m_pend && m_left == 0 && out_ready;
      if (clr_cnt) begin
        m_cnt = 0;
        m_cnt_s = 0;
      end else if (m_hs && m_in) begin
        if (m_cnt < (1 << CW) - 1) m_cnt++;
        if (m_cnt_s < (1 << SW) - 1) m_cnt_s++;
      end
      if (!m_pend) begin
        if (in_valid) begin
          m_g0 = side(x0, y0, x1, y1, x2, y2);
          m_g1 = side(x0, y0, x2, y2, x3, y3);
          m_g2 = side(x0, y0, x3, y3, x1, y1);
          m_in = (m_g0 == m_g1) && (m_g1 == m_g2);
          m_left = 3;
`ifdef TRI_EARLY_EXIT_EN
          if (m_g0 != m_g1) m_left = 2;
`endif
          m_pend = 1;
        end
      end else if (m_left > 0) begin
        m_left--;
      end else if (out_ready) begin
        m_pend = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_q(input int px, py, ax, ay, bx, by, cx, cy);
    x0 = W'(px); y0 = W'(py);
    x1 = W'(ax); y1 = W'(ay);
    x2 = W'(bx); y2 = W'(by);
    x3 = W'(cx); y3 = W'(cy);
  endtask

  task automatic send(input int px, py, ax, ay, bx, by, cx, cy,
                      output int acc);
    bit ok;
    ok = 0;
    acc = cyc;
    set_q(px, py, ax, ay, bx, by, cx, cy);
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #2;
        acc = cyc;
        ok = 1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_valid(input int acc, output int lat);
    lat = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = cyc - acc;
        break;
      end
    end
    if (lat < 0) chk("valid_timeout", 0, 1);
  endtask

  task automatic query(input string nm, input int px, py, ax, ay,
                       bx, by, cx, cy, input int e_in, e_lat, e_cnt);
    int acc, lat;
    send(px, py, ax, ay, bx, by, cx, cy, acc);
    wait_valid(acc, lat);
    chk({nm, "_lat"}, lat, e_lat);
    chk({nm, "_in"}, out_in, e_in);
    tick();
    chk({nm, "_cnt"}, hit_cnt, e_cnt);
  endtask

  function automatic int rc();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return -2048;
    if (r == 1) return 2047;
    return int'($urandom_range(0, 400)) - 200;
  endfunction

  initial begin
    int acc, lat;
    bit held;
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_in", out_in, 0);
    chk("reset_hit_cnt", hit_cnt, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    query("inside", 10, 10, 0, 0, 100, 0, 0, 100, 1, 3, 1);
    query("outside", 200, 200, 0, 0, 100, 0, 0, 100, 0, LOUT, 1);
    query("extreme", 0, 0, -2048, -2048, 2047, -2048, 0, 2047, 1, 3, 2);
    query("degen", 5, 5, 5, 5, 5, 5, 5, 5, 1, 3, 3);
    query("vertex", 0, 0, 0, 0, 100, 0, 0, 100, 1, 3, 4);

    out_ready = 1'b0;
    send(10, 10, 0, 0, 100, 0, 0, 100, acc);
    wait_valid(acc, lat);
    chk("bp_lat", lat, 3);
    held = out_in;
    for (int i = 0; i < 5; i++) begin
      tick();
      set_q(200, 200, 1, 2, 3, 4, 5, 6);
      in_valid = 1'b1;
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_in_held", out_in, held);
      chk("bp_in_ready", in_ready, 0);
    end
    tick();
    out_ready = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("bp_idle", in_ready, 1);
    chk("bp_busy", busy, 0);
    chk("bp_cnt", hit_cnt, 5);

    send(10, 10, 0, 0, 100, 0, 0, 100, acc);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_cnt", hit_cnt, 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_result", out_valid, 0);
    end
    tick();

    for (int i = 1; i <= 8; i++)
      query("sat", 10, 10, 0, 0, 100, 0, 0, 100, 1, 3, i);
    chk("sat_small", hit_cnt_s, 7);
    query("sat_hold", 10, 10, 0, 0, 100, 0, 0, 100, 1, 3, 9);
    chk("sat_small_hold", hit_cnt_s, 7);

    out_ready = 1'b0;
    send(10, 10, 0, 0, 100, 0, 0, 100, acc);
    wait_valid(acc, lat);
    tick();
    clr_cnt = 1'b1;
    out_ready = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_prio", hit_cnt, 0);
    chk("clr_prio_s", hit_cnt_s, 0);
    chk("clr_idle", in_ready, 1);

    for (int i = 0; i < 4000; i++) begin
      tick();
      set_q(rc(), rc(), rc(), rc(), rc(), rc(), rc(), rc());
      if ($urandom_range(0, 3) == 0) begin
        x1 = x0;
        y1 = y0;
      end
      in_valid = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 9) < 7);
      clr_cnt = ($urandom_range(0, 99) < 2);
    end
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    clr_cnt = 1'b0;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
